// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline controller state, register index and counter widths.
package cpu_types_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned LU_CNT_W = 3;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } pipe_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in ID/EX and the sources read in IF/ID.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_dREN,
  input  regbits_t idex_wsel,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  input  logic     ifid_uses_rt,
  output logic     luh
);

  // r0 is never a real destination, so a load into it cannot create a hazard
  always_comb begin
    luh = idex_dREN && (idex_wsel != '0) &&
          ((idex_wsel == ifid_rs) || (ifid_uses_rt && (idex_wsel == ifid_rt)));
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: latch en/flush, PC enable, halt-drain handshake
// with the dcache and saturating stall/redirect performance counters.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LU_BUBBLES = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             exmem_pcsrc,
  input  logic             exmem_halt,
  input  logic             idex_dREN,
  input  regbits_t         idex_wsel,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             dflush_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic             memwb_flush,
  output logic             dflush_req,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);

  pipe_state_t         state, state_nx;
  logic [LU_CNT_W-1:0] lu_cnt, lu_nx;
  logic                luh;
  logic                dstall;
  logic                stall_inc;
  logic                redir_inc;

  hazard_detect u_hazard_detect (
    .idex_dREN    (idex_dREN),
    .idex_wsel    (idex_wsel),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .luh          (luh)
  );

  // Data access in MEM that has not completed yet freezes the front of the pipe
  always_comb begin
    dstall = (exmem_dREN || exmem_dWEN) && !dhit;
  end

  // Next state and per-cycle latch controls; flushed latches also drop their enable
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_en     = 1'b0;
    idex_flush  = 1'b0;
    exmem_en    = 1'b0;
    exmem_flush = 1'b0;
    memwb_en    = 1'b0;
    memwb_flush = 1'b0;
    dflush_req  = 1'b0;
    state_nx    = state;
    lu_nx       = lu_cnt;
    stall_inc   = 1'b0;
    redir_inc   = 1'b0;

    case (state)
      RUN, LU_STALL: begin
        if (exmem_halt && !dstall) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          memwb_en    = 1'b1;
          state_nx    = DRAIN;
          lu_nx       = '0;
        end else if (dstall) begin
          memwb_flush = 1'b1;
          stall_inc   = 1'b1;
        end else if (exmem_pcsrc) begin
          pc_en       = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          memwb_en    = 1'b1;
          redir_inc   = 1'b1;
          state_nx    = RUN;
          lu_nx       = '0;
        end else if (luh || (state == LU_STALL)) begin
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          stall_inc  = 1'b1;
          if (state == RUN) begin
            if (LU_BUBBLES > 1) begin
              state_nx = LU_STALL;
              lu_nx    = LU_CNT_W'(LU_BUBBLES - 1);
            end
          end else begin
            lu_nx = lu_cnt - LU_CNT_W'(1);
            if (lu_cnt == LU_CNT_W'(1)) begin
              state_nx = RUN;
            end
          end
        end else if (!ihit) begin
          ifid_flush = 1'b1;
          idex_en    = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          stall_inc  = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
      end
      DRAIN: begin
        dflush_req = 1'b1;
        if (dflush_done) begin
          state_nx = HALTED;
        end
      end
      HALTED: begin
        state_nx = HALTED;
      end
      default: begin
        state_nx = RUN;
        lu_nx    = '0;
      end
    endcase
  end

  // State, bubble counter, sticky halt and saturating performance counters
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state        <= RUN;
      lu_cnt       <= '0;
      halt         <= 1'b0;
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      state  <= state_nx;
      lu_cnt <= lu_nx;
      halt   <= halt || (state_nx == HALTED);
      if (stall_inc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (redir_inc && (redirect_cnt != '1)) begin
        redirect_cnt <= redirect_cnt + CNT_W'(1);
      end
    end
  end

endmodule
